// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: SCLK waveform plus shift/sample strobes.
// Finite bursts of NBITS bits; a guard interval follows each burst before DONE.
module spi_sclk_gen #(
  parameter int DIV_W = 10,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [DIV_W-1:0] HALF_DIV,
  input  logic [CNT_W-1:0] NBITS,
  input  logic             CPOL,
  input  logic             CPHA,
  output logic             SCLK,
  output logic             SHIFT_STB,
  output logic             SAMPLE_STB,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GUARD
  } state_t;

  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [CNT_W:0]   ONE_E = (CNT_W+1)'(1);

  state_t           r_state;
  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_nbits;
  logic [CNT_W:0]   r_ecnt;
  logic             r_cpol;
  logic             r_cpha;
  logic             r_sclk;
  logic             r_shift;
  logic             r_sample;
  logic             r_busy;
  logic             r_done;

  logic             w_idle;
  logic             w_accept;
  logic [DIV_W-1:0] w_half_in;
  logic [DIV_W-1:0] w_h;
  logic [DIV_W-1:0] w_c;
  logic [DIV_W-1:0] w_cnext;
  logic             w_tick;
  logic [CNT_W:0]   w_enext;
  logic [CNT_W:0]   w_elast;
  logic             w_final;
  logic             w_lead;
  logic             w_cpha;
  logic             w_shift;
  logic             w_sample;

  // The accepting edge counts as half-counter step 0, so with H=1 the
  // first SCLK transition is already registered on that edge. In IDLE the
  // step is evaluated against the live inputs about to be latched.
  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle & START & (NBITS != '0);
  assign w_half_in = (HALF_DIV == '0) ? ONE_D : HALF_DIV;
  assign w_h       = w_idle ? w_half_in : r_half;
  assign w_c       = w_idle ? '0 : r_hcnt;
  assign w_tick    = (w_c == (w_h - ONE_D));
  assign w_cnext   = w_tick ? '0 : (w_c + ONE_D);

  // Edge bookkeeping: odd edges lead, edge 2N is the last one.
  assign w_enext = (w_idle ? '0 : r_ecnt) + ONE_E;
  assign w_elast = w_idle ? {NBITS, 1'b0} : {r_nbits, 1'b0};
  assign w_final = (w_enext == w_elast);
  assign w_lead  = w_enext[0];
  assign w_cpha  = w_idle ? CPHA : r_cpha;

  // Strobe decode for the edge being registered this cycle.
  assign w_shift  = w_tick & (w_cpha ? w_lead : (~w_lead & ~w_final));
  assign w_sample = w_tick & (w_cpha ? ~w_lead : w_lead);

  // Burst state machine with registered SCLK, strobes, BUSY and DONE.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_state  <= S_IDLE;
      r_half   <= '0;
      r_hcnt   <= '0;
      r_nbits  <= '0;
      r_ecnt   <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_sclk   <= 1'b0;
      r_shift  <= 1'b0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_shift  <= 1'b0;
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_sclk <= CPOL;
          r_busy <= 1'b0;
          r_hcnt <= '0;
          r_ecnt <= '0;
          if (w_accept) begin
            r_state  <= S_RUN;
            r_half   <= w_half_in;
            r_nbits  <= NBITS;
            r_cpol   <= CPOL;
            r_cpha   <= CPHA;
            r_busy   <= 1'b1;
            r_hcnt   <= w_cnext;
            r_shift  <= w_shift;
            r_sample <= w_sample;
            if (w_tick) begin
              r_sclk <= ~CPOL;
              r_ecnt <= w_enext;
            end
          end
        end
        S_RUN: begin
          if (ABORT) begin
            r_state <= S_IDLE;
            r_sclk  <= r_cpol;
            r_busy  <= 1'b0;
            r_hcnt  <= '0;
            r_ecnt  <= '0;
          end else begin
            r_hcnt   <= w_cnext;
            r_shift  <= w_shift;
            r_sample <= w_sample;
            if (w_tick) begin
              r_ecnt <= w_enext;
              r_sclk <= ~r_sclk;
              if (w_final) begin
                r_state <= S_GUARD;
                r_sclk  <= r_cpol;
                r_hcnt  <= '0;
                r_ecnt  <= '0;
              end
            end
          end
        end
        S_GUARD: begin
          r_sclk <= r_cpol;
          if (ABORT) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_hcnt  <= '0;
            r_ecnt  <= '0;
          end else if (w_tick) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hcnt  <= '0;
          end else begin
            r_hcnt <= w_cnext;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_hcnt  <= '0;
          r_ecnt  <= '0;
        end
      endcase
    end
  end

  assign SCLK       = r_sclk;
  assign SHIFT_STB  = r_shift;
  assign SAMPLE_STB = r_sample;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: directed bursts then random traffic,
// checked every cycle against a closed-form waveform model.
module tb_spi_sclk_gen;

  localparam int DW = 10;
  localparam int CW = 6;

  logic          CLK = 1'b0;
  logic          NRST = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic          CPOL = 1'b0;
  logic          CPHA = 1'b0;
  logic [DW-1:0] HALF_DIV = '0;
  logic [CW-1:0] NBITS = '0;
  logic          SCLK;
  logic          SHIFT_STB;
  logic          SAMPLE_STB;
  logic          BUSY;
  logic          DONE;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: burst parameters captured at acceptance, waveform by formula.
  bit m_act = 1'b0;
  int m_t0, m_h, m_n;
  bit m_cpol, m_cpha;
  bit e_sclk, e_shift, e_sample, e_busy, e_done;

  always #5 CLK = ~CLK;

  spi_sclk_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .NRST(NRST), .START(START), .ABORT(ABORT),
    .HALF_DIV(HALF_DIV), .NBITS(NBITS), .CPOL(CPOL), .CPHA(CPHA),
    .SCLK(SCLK), .SHIFT_STB(SHIFT_STB), .SAMPLE_STB(SAMPLE_STB),
    .BUSY(BUSY), .DONE(DONE)
  );

  // Expected outputs for the cycle following the edge just taken.
  // Edge j of a burst is at k = j*H after the accepting cycle; DONE at
  // k = H*(2N+1); BUSY in between.
  task automatic model_edge();
    int k, t, j;
    bit lead;
    cyc++;
    e_shift = 0; e_sample = 0; e_busy = 0; e_done = 0;
    if (!NRST) begin
      m_act = 0; e_sclk = 0; return;
    end
    if (m_act && ABORT) begin
      m_act = 0; e_sclk = m_cpol; return;
    end
    if (!m_act) begin
      e_sclk = CPOL;
      if (!(START && NBITS != 0)) return;
      m_act = 1; m_t0 = cyc - 1;
      m_h = (HALF_DIV == 0) ? 1 : int'(HALF_DIV);
      m_n = int'(NBITS); m_cpol = CPOL; m_cpha = CPHA;
    end
    k = cyc - m_t0;
    t = m_h * (2 * m_n + 1);
    if (k >= t) begin
      m_act = 0; e_done = 1; e_sclk = m_cpol; return;
    end
    e_busy = 1;
    j = k / m_h;
    e_sclk = m_cpol ^ (j % 2 == 1);
    if (k % m_h == 0 && j >= 1) begin
      lead = (j % 2 == 1);
      if (m_cpha) begin
        e_shift = lead; e_sample = !lead;
      end else begin
        e_sample = lead; e_shift = !lead && (j != 2 * m_n);
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    chk("sclk", SCLK, e_sclk);
    chk("shift", SHIFT_STB, e_shift);
    chk("sample", SAMPLE_STB, e_sample);
    chk("busy", BUSY, e_busy);
    chk("done", DONE, e_done);
  endtask

  task automatic go(input int h, input int n, input bit pol, input bit pha);
    HALF_DIV = DW'(h); NBITS = CW'(n); CPOL = pol; CPHA = pha;
    START = 1; tick(); START = 0;
  endtask

  initial begin
    int n;
    // reset state, also with START/ABORT asserted
    START = 1; ABORT = 1; NBITS = 3; HALF_DIV = 2;
    repeat (3) tick();
    START = 0; ABORT = 0; NRST = 1;
    // idle SCLK follows live CPOL one cycle late
    CPOL = 1; repeat (2) tick();
    CPOL = 0; repeat (2) tick();
    // H=2 N=2 mode 0
    go(2, 2, 0, 0); repeat (12) tick();
    // H=1 N=3 CPOL=1 CPHA=1
    CPOL = 1; tick();
    go(1, 3, 1, 1); repeat (9) tick();
    // HALF_DIV=0 behaves as 1; NBITS=0 ignored
    go(0, 1, 0, 0); repeat (5) tick();
    go(1, 1, 0, 1); repeat (5) tick();
    go(2, 0, 0, 0); repeat (4) tick();
    // START while busy ignored, inputs frozen mid-burst
    go(2, 2, 0, 0);
    START = 1; HALF_DIV = 5; CPOL = 1; tick();
    START = 0; repeat (12) tick();
    CPOL = 0; tick();
    // ABORT at t0+5
    go(2, 2, 0, 0); repeat (4) tick();
    ABORT = 1; tick(); ABORT = 0;
    repeat (8) tick();
    // ABORT in guard
    go(3, 1, 1, 0); repeat (7) tick();
    ABORT = 1; tick(); ABORT = 0;
    repeat (5) tick();
    // START in the DONE cycle with values changed mid-burst
    go(2, 1, 0, 0);
    HALF_DIV = 3; CPOL = 1; CPHA = 1; NBITS = 2;
    n = 0;
    while (DONE !== 1'b1 && n < 200) begin tick(); n++; end
    if (DONE !== 1'b1) begin
      total++; bad++;
      $error("FAIL done_wait timeout observed=%b expected=1", DONE);
    end
    START = 1; tick(); START = 0;
    repeat (20) tick();
    // reset mid-run
    go(3, 2, 0, 1); repeat (4) tick();
    NRST = 0; CPOL = 1; tick();
    NRST = 1; repeat (4) tick();
    // random traffic
    for (int b = 0; b < 60; b++) begin
      go($urandom_range(0, 4), $urandom_range(0, 5),
         1'($urandom), 1'($urandom));
      for (int c = 0; c < 70; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          HALF_DIV = DW'($urandom_range(0, 7));
          NBITS = CW'($urandom_range(0, 5));
          CPOL = 1'($urandom); CPHA = 1'($urandom);
        end
        START = ($urandom_range(0, 5) == 0);
        ABORT = m_act && ($urandom_range(0, 40) == 0);
        NRST = !($urandom_range(0, 150) == 0);
        tick();
      end
      START = 0; ABORT = 0; NRST = 1;
    end
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
